// File: rtl/pattern_scan_arbiter.sv
// Round-robin arbiter sharing one serial 1101 detector (one-hot Moore) among NREQ word producers.
// Define PSA_OVERLAP_EN to count overlapping matches (S1101 on 1 -> S11); default restarts at S1.
module pattern_scan_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  out,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [CNT_W-1:0]      match_cnt
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int D_S0    = 0;
  localparam int D_S1    = 1;
  localparam int D_S11   = 2;
  localparam int D_S110  = 3;
  localparam int D_S1101 = 4;
`ifdef PSA_OVERLAP_EN
  localparam int D_RESTART = D_S11;
`else
  localparam int D_RESTART = D_S1;
`endif
  localparam logic [4:0]      DET_IDLE = 5'b00001;
  localparam logic [NREQ-1:0] GNT_ONE  = NREQ'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_REPORT} state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_word;
  logic [BCW-1:0]   r_bitcnt;
  logic [4:0]       r_det, w_det_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next, r_match_cnt;
  logic [IDW-1:0]   r_last, r_done_id, w_win, w_idx;
  logic [NREQ-1:0]  r_gnt;
  logic             w_found, w_bit, w_last_bit;
  logic [WIDTH-1:0] w_words [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_words[gi] = data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Search starts one past the last winner, wrapping, so the last winner is lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IDW'((int'(r_last) + k) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_bit      = r_word[WIDTH-1];
  assign w_last_bit = (r_bitcnt == BCW'(WIDTH - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_found) w_state_next = ST_SHIFT;
      ST_SHIFT:  if (w_last_bit) w_state_next = ST_REPORT;
      ST_REPORT: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_det_next = '0;
    case (1'b1)
      r_det[D_S0]:    if (w_bit) w_det_next[D_S1]      = 1'b1; else w_det_next[D_S0]   = 1'b1;
      r_det[D_S1]:    if (w_bit) w_det_next[D_S11]     = 1'b1; else w_det_next[D_S0]   = 1'b1;
      r_det[D_S11]:   if (w_bit) w_det_next[D_S11]     = 1'b1; else w_det_next[D_S110] = 1'b1;
      r_det[D_S110]:  if (w_bit) w_det_next[D_S1101]   = 1'b1; else w_det_next[D_S0]   = 1'b1;
      r_det[D_S1101]: if (w_bit) w_det_next[D_RESTART] = 1'b1; else w_det_next[D_S0]   = 1'b1;
      default:        w_det_next[D_S0] = 1'b1;
    endcase
  end

  assign w_cnt_next = (w_det_next[D_S1101] && (r_cnt != '1)) ? r_cnt + 1'b1 : r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_word      <= '0;
      r_bitcnt    <= '0;
      r_det       <= DET_IDLE;
      r_cnt       <= '0;
      r_match_cnt <= '0;
      r_done_id   <= '0;
      r_last      <= IDW'(NREQ - 1);
      r_gnt       <= '0;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_word   <= w_words[w_win];
            r_bitcnt <= '0;
            r_det    <= DET_IDLE;
            r_cnt    <= '0;
            r_last   <= w_win;
            r_gnt    <= GNT_ONE << w_win;
          end
        end
        ST_SHIFT: begin
          r_word   <= r_word << 1;
          r_bitcnt <= r_bitcnt + 1'b1;
          r_det    <= w_det_next;
          r_cnt    <= w_cnt_next;
          // The match ending on bit 0 must reach the port on the same edge as REPORT entry.
          if (w_last_bit) begin
            r_match_cnt <= w_cnt_next;
            r_done_id   <= r_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign busy      = (r_state != ST_IDLE);
  assign out       = (r_state == ST_SHIFT) && r_det[D_S1101];
  assign done      = (r_state == ST_REPORT);
  assign done_id   = r_done_id;
  assign match_cnt = r_match_cnt;

endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// Scoreboard bench for pattern_scan_arbiter: a per-cycle arbitration model pushes expected
// grants/results into queues; a monitor pops and compares whenever gnt or done appears.
module tb_pattern_scan_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int IDW   = 2;
`ifdef PSA_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] data = '0;
  logic [NREQ-1:0]       gnt;
  logic                  busy, out, done;
  logic [IDW-1:0]        done_id;
  logic [CNT_W-1:0]      match_cnt;

  pattern_scan_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(CNT_W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt), .busy(busy), .out(out),
    .done(done), .done_id(done_id), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [NREQ-1:0] mask; int cyc; } gexp_t;
  typedef struct { int id; int cnt; int outs; int cyc; } dexp_t;
  gexp_t gq[$];
  dexp_t dq[$];
  int ptr = NREQ - 1;
  int cd  = 0;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Matches are counted from the bit string directly: leftmost-first, with or without overlap.
  function automatic void ref_scan(input logic [WIDTH-1:0] w, output int cnt, output int outs);
    int last_end;
    logic [3:0] win4;
    cnt = 0; outs = 0; last_end = -1;
    for (int j = 3; j < WIDTH; j++) begin
      win4 = {w[WIDTH-1-(j-3)], w[WIDTH-1-(j-2)], w[WIDTH-1-(j-1)], w[WIDTH-1-j]};
      if (win4 == 4'b1101 && (OVERLAP || (j - 3 > last_end))) begin
        last_end = j;
        if (cnt < (1 << CNT_W) - 1) cnt++;
        if (j < WIDTH - 1) outs++;
      end
    end
  endfunction

  // Decide what the coming clock edge does: an arbitration slot opens every WIDTH+2 edges.
  task automatic model_step();
    int win, c, o;
    gexp_t g;
    dexp_t d;
    if (!rst) return;
    if (cd > 0) begin
      cd--;
      return;
    end
    if (req == '0) return;
    win = -1;
    for (int k = 1; k <= NREQ; k++) begin
      if (win < 0 && req[(ptr + k) % NREQ]) win = (ptr + k) % NREQ;
    end
    ptr = win;
    ref_scan(data[win*WIDTH +: WIDTH], c, o);
    g.mask = NREQ'(1) << win;
    g.cyc  = cyc + 1;
    gq.push_back(g);
    d.id = win; d.cnt = c; d.outs = o; d.cyc = cyc + 1 + WIDTH;
    dq.push_back(d);
    cd = WIDTH + 1;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    gq.delete();
    dq.delete();
    ptr = NREQ - 1;
    cd  = 0;
    #1;
    chk("async_rst_outs", int'({gnt, busy, out, done, done_id, match_cnt}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor
  initial begin
    int out_run, hold;
    gexp_t g;
    dexp_t d;
    out_run = 0; hold = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        out_run = 0; hold = 0;
        chk("rst_outs", int'({gnt, busy, out, done, done_id, match_cnt}), 0);
      end else begin
        if (gnt != '0) begin
          out_run = 0;
          if (gq.size() == 0) chk("gnt_unexpected", int'(gnt), 0);
          else begin
            g = gq.pop_front();
            chk("gnt_mask", int'(gnt), int'(g.mask));
            chk("gnt_cycle", cyc, g.cyc);
          end
        end else if (gq.size() > 0 && gq[0].cyc <= cyc) begin
          chk("gnt_missing", 0, int'(gq[0].mask));
          void'(gq.pop_front());
        end
        if (out) begin
          out_run++;
          chk("out_while_busy", int'(busy), 1);
        end
        if (done) begin
          chk("busy_in_report", int'(busy), 1);
          if (dq.size() == 0) chk("done_unexpected", int'(done), 0);
          else begin
            d = dq.pop_front();
            chk("done_id", int'(done_id), d.id);
            chk("match_cnt", int'(match_cnt), d.cnt);
            chk("out_pulses", out_run, d.outs);
            chk("done_cycle", cyc, d.cyc);
            hold = d.cnt;
          end
        end else begin
          if (dq.size() > 0 && dq[0].cyc <= cyc) begin
            chk("done_missing", 0, 1);
            void'(dq.pop_front());
          end
          chk("match_cnt_hold", int'(match_cnt), hold);
        end
      end
    end
  end

  // Driver
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_outs", int'({gnt, busy, out, done, match_cnt}), 0);
    end
    // Single requester, 8'hDB
    req = 4'b0001; data[7:0] = 8'hDB;
    tick();
    req = '0;
    ticks(WIDTH + 4);
    // All requesters held, 8'hDD everywhere
    do_reset();
    req = '1;
    for (int i = 0; i < NREQ; i++) data[i*WIDTH +: WIDTH] = 8'hDD;
    ticks(5 * (WIDTH + 2));
    req = '0;
    ticks(WIDTH + 4);
    // Requester 2 with all-zero then all-one words
    do_reset();
    req = 4'b0100; data[2*WIDTH +: WIDTH] = 8'h00;
    tick();
    req = '0;
    ticks(WIDTH + 3);
    req = 4'b0100; data[2*WIDTH +: WIDTH] = 8'hFF;
    tick();
    req = '0;
    ticks(WIDTH + 4);
    // Reset mid-SHIFT, then re-arbitrate from the reset pointer
    do_reset();
    req = 4'b0110;
    for (int i = 0; i < NREQ; i++) data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    ticks(4);
    do_reset();
    tick();
    req = '0;
    ticks(WIDTH + 4);
    // Requester 3 pulses during another word and drops before IDLE
    do_reset();
    req = 4'b0001; data[7:0] = 8'hB6;
    tick();
    req = '0;
    ticks(2);
    req = 4'b1000;
    ticks(2);
    req = '0;
    ticks(WIDTH + 4);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
      for (int k = 0; k < NREQ; k++) data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
      tick();
    end
    req = '0;
    ticks(WIDTH + 4);
    chk("grants_drained", gq.size(), 0);
    chk("results_drained", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
